// File: rtl/varredor_triangulo.sv
// Triangle rasterizer: scans the vertex bounding box row-major, 1 cycle per point, and emits inside pixels.
// Emitted pixels use valid/ready; the scan holds while pix_valid is not accepted.
module varredor_triangulo #(
  parameter int W  = 12,
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inicio,
  input  logic [W-1:0]  px1,
  input  logic [W-1:0]  py1,
  input  logic [W-1:0]  px2,
  input  logic [W-1:0]  py2,
  input  logic [W-1:0]  px3,
  input  logic [W-1:0]  py3,
  output logic [W-1:0]  px,
  output logic [W-1:0]  py,
  input  logic          entrada,
  output logic [W-1:0]  pix_x,
  output logic [W-1:0]  pix_y,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          ocupado,
  output logic          fim,
  output logic [CW-1:0] contagem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BBOX,
    S_SCAN,
    S_EMIT,
    S_DONE
  } estado_t;

  estado_t r_estado, w_prox;

  logic [W-1:0]  r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  logic [W-1:0]  r_xmin, r_xmax, r_ymin, r_ymax;
  logic [W-1:0]  r_px, r_py, r_pix_x, r_pix_y;
  logic          r_pix_valid;
  logic [CW-1:0] r_contagem;

  logic [W-1:0]  w_xmin, w_xmax, w_ymin, w_ymax;
  logic          w_fim_linha, w_ultimo, w_avanca, w_aceita;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign w_xmin = min3(r_x1, r_x2, r_x3);
  assign w_xmax = max3(r_x1, r_x2, r_x3);
  assign w_ymin = min3(r_y1, r_y2, r_y3);
  assign w_ymax = max3(r_y1, r_y2, r_y3);

  // End-of-box is detected before incrementing, so coordinates at 2^W-1 never wrap.
  assign w_fim_linha = (r_px == r_xmax);
  assign w_ultimo    = w_fim_linha && (r_py == r_ymax);
  assign w_aceita    = (r_estado == S_IDLE) && inicio;
  assign w_avanca    = ((r_estado == S_SCAN) && !entrada) ||
                       ((r_estado == S_EMIT) && pix_ready);

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      S_IDLE:  if (inicio) w_prox = S_BBOX;
      S_BBOX:  w_prox = S_SCAN;
      S_SCAN: begin
        if (entrada)       w_prox = S_EMIT;
        else if (w_ultimo) w_prox = S_DONE;
      end
      S_EMIT:  if (pix_ready) w_prox = w_ultimo ? S_DONE : S_SCAN;
      S_DONE:  w_prox = S_IDLE;
      default: w_prox = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_estado <= S_IDLE;
    else     r_estado <= w_prox;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0; r_x3 <= '0; r_y3 <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      r_px <= '0; r_py <= '0; r_pix_x <= '0; r_pix_y <= '0;
      r_pix_valid <= 1'b0;
      r_contagem  <= '0;
    end else begin
      if (w_aceita) begin
        r_x1 <= px1; r_y1 <= py1;
        r_x2 <= px2; r_y2 <= py2;
        r_x3 <= px3; r_y3 <= py3;
        r_contagem <= '0;
      end
      if (r_estado == S_BBOX) begin
        r_xmin <= w_xmin; r_xmax <= w_xmax;
        r_ymin <= w_ymin; r_ymax <= w_ymax;
        r_px   <= w_xmin; r_py   <= w_ymin;
      end
      if ((r_estado == S_SCAN) && entrada) begin
        r_pix_x     <= r_px;
        r_pix_y     <= r_py;
        r_pix_valid <= 1'b1;
      end
      if ((r_estado == S_EMIT) && pix_ready) begin
        r_pix_valid <= 1'b0;
        if (r_contagem != {CW{1'b1}}) r_contagem <= r_contagem + 1'b1;
      end
      if (w_avanca && !w_ultimo) begin
        if (!w_fim_linha) begin
          r_px <= r_px + 1'b1;
        end else begin
          r_px <= r_xmin;
          r_py <= r_py + 1'b1;
        end
      end
    end
  end

  assign px        = r_px;
  assign py        = r_py;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_valid = r_pix_valid;
  assign contagem  = r_contagem;
  assign ocupado   = (r_estado != S_IDLE);
  assign fim       = (r_estado == S_DONE);

endmodule

// File: tb/tb_varredor_triangulo.sv
// Directed bench for varredor_triangulo, paired with an edge-function point-in-triangle tester.
module tb_varredor_triangulo;
  localparam int W  = 12;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inicio = 1'b0;
  logic [W-1:0]  px1 = '0, py1 = '0, px2 = '0, py2 = '0, px3 = '0, py3 = '0;
  logic [W-1:0]  px, py, pix_x, pix_y;
  logic          entrada;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          ocupado, fim;
  logic [CW-1:0] contagem;

  int vectors = 0;
  int miscompares = 0;
  int tx1 = 0, ty1 = 0, tx2 = 0, ty2 = 0, tx3 = 0, ty3 = 0;
  int cnt_base, cnt_tmp;

  varredor_triangulo #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .inicio(inicio),
    .px1(px1), .py1(py1), .px2(px2), .py2(py2), .px3(px3), .py3(py3),
    .px(px), .py(py), .entrada(entrada),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ocupado(ocupado), .fim(fim), .contagem(contagem)
  );

  always #5 clk = ~clk;

  // Inclusive edges; a fully degenerate triangle (all vertices equal) counts its single point as inside.
  function automatic bit inside_tri(input int x, input int y, input int ax, input int ay,
                                    input int bx, input int by, input int cx, input int cy);
    int d1, d2, d3;
    d1 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
    d2 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
    d3 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
    return ((d1 >= 0) && (d2 >= 0) && (d3 >= 0)) || ((d1 <= 0) && (d2 <= 0) && (d3 <= 0));
  endfunction

  always_comb entrada = inside_tri(int'(px), int'(py), tx1, ty1, tx2, ty2, tx3, ty3);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_tri(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3);
    tx1 = x1; ty1 = y1; tx2 = x2; ty2 = y2; tx3 = x3; ty3 = y3;
    px1 = W'(x1); py1 = W'(y1); px2 = W'(x2); py2 = W'(y2); px3 = W'(x3); py3 = W'(y3);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge (BBOX cycle).
  task automatic start();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("bbox_ocupado", ocupado, 1);
    chk("bbox_cnt_clr", contagem, 0);
  endtask

  task automatic run_scan(input int xmin, input int xmax, input int ymin, input int ymax,
                          input int stall, output int cnt);
    int  edges;
    int  npts;
    int  waitn;
    bit  stalled;
    cnt = 0;
    edges = 0;
    stalled = 1'b0;
    npts = (xmax - xmin + 1) * (ymax - ymin + 1);
    tick(); edges++;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        chk("scan_pt", {px, py}, {W'(x), W'(y)});
        if (inside_tri(x, y, tx1, ty1, tx2, ty2, tx3, ty3)) begin
          if (stall > 0 && !stalled) pix_ready = 1'b0;
          tick(); edges++;
          chk("emit_vld", pix_valid, 1);
          chk("emit_pix", {pix_x, pix_y}, {W'(x), W'(y)});
          if (stall > 0 && !stalled) begin
            stalled = 1'b1;
            for (int s = 0; s < stall; s++) begin
              tick(); edges++;
              chk("stall_vld", pix_valid, 1);
              chk("stall_pix", {pix_x, pix_y}, {W'(x), W'(y)});
              chk("stall_pt", {px, py}, {W'(x), W'(y)});
            end
            pix_ready = 1'b1;
          end
          cnt++;
        end
        tick(); edges++;
      end
    end
    waitn = 0;
    while (!fim && waitn < 4) begin
      tick(); edges++; waitn++;
    end
    chk("fim_seen", fim, 1);
    chk("scan_cycles", edges, 1 + npts + cnt + stall);
    chk("contagem", contagem, cnt);
    chk("end_pt", {px, py}, {W'(xmax), W'(ymax)});
    chk("done_vld", pix_valid, 0);
    tick();
    chk("fim_pulse", fim, 0);
    chk("idle", ocupado, 0);
    chk("cnt_hold", contagem, cnt);
    chk("pt_hold", {px, py}, {W'(xmax), W'(ymax)});
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_coord", {px, py, pix_x, pix_y}, 0);
    chk("rst_flags", {pix_valid, ocupado, fim, contagem}, 0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", ocupado, 0);

    // Main triangle, free-flowing consumer
    set_tri(15, 15, 35, 10, 15, 30);
    start();
    run_scan(15, 35, 10, 30, 0, cnt_base);
    chk("tri_cnt_hand", contagem, 171);

    // Same triangle, consumer stalls the first inside pixel for 10 cycles
    start();
    run_scan(15, 35, 10, 30, 10, cnt_tmp);
    chk("stall_cnt_same", contagem, cnt_base);

    // All vertices coincident: single point, fim in cycle k+4
    set_tri(5, 5, 5, 5, 5, 5);
    start();
    run_scan(5, 5, 5, 5, 0, cnt_tmp);
    chk("point_cnt_hand", contagem, 1);

    // Bounding box touching 2^W-1 on both axes
    set_tri(4090, 4095, 4095, 4090, 4095, 4095);
    start();
    run_scan(4090, 4095, 4090, 4095, 0, cnt_tmp);
    chk("corner_cnt_hand", contagem, 21);

    // Restart requests while busy are ignored; async reset mid-EMIT
    set_tri(15, 15, 35, 10, 15, 30);
    start();
    inicio = 1'b1;
    px1 = W'(5); py1 = W'(5); px2 = W'(5); py2 = W'(5); px3 = W'(5); py3 = W'(5);
    repeat (22) tick();
    chk("busy_emit_vld", pix_valid, 1);
    chk("busy_emit_pix", {pix_x, pix_y}, {W'(35), W'(10)});
    chk("busy_pt", {px, py}, {W'(35), W'(10)});
    inicio = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_coord", {px, py, pix_x, pix_y}, 0);
    chk("async_rst_flags", {pix_valid, ocupado, fim, contagem}, 0);
    tick();
    chk("rst_hold_flags", {pix_valid, ocupado, fim, contagem}, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("no_resume_ocupado", ocupado, 0);
    chk("no_resume_pt", {px, py}, 0);
    set_tri(15, 15, 35, 10, 15, 30);
    start();
    run_scan(15, 35, 10, 30, 0, cnt_tmp);
    chk("rescan_cnt_hand", contagem, 171);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/varredor_triangulo.md
VARREDOR_TRIANGULO -- requirements
Module: varredor_triangulo

Interface
REQ-001 Parameter W, default 12, coordinate width, same as point-in-triangle tester.
REQ-002 Parameter CW, default 24, width of the inside-pixel counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 inicio  in  1  start request, sampled only in IDLE.
REQ-006 px1, py1, px2, py2, px3, py3  in  W each  triangle vertices, unsigned, sampled when inicio is accepted.
REQ-007 px, py  out  W each  registered scan point driven to the external tester.
REQ-008 entrada  in  1  tester verdict for the current px, py (combinational, same cycle).
REQ-009 pix_x, pix_y  out  W each  coordinates of the emitted inside pixel.
REQ-010 pix_valid  out  1  emitted pixel valid; pix_ready  in  1  consumer accepts.
REQ-011 ocupado  out  1  high in every state except IDLE.
REQ-012 fim  out  1  one-cycle pulse at end of scan.
REQ-013 contagem  out  CW  number of pixels accepted in current/last scan.

Function
REQ-014 FSM states IDLE, BBOX, SCAN, EMIT, DONE; encoding is free.
REQ-015 IDLE: on inicio=1, latch six vertices, clear contagem, go to BBOX; otherwise stay.
REQ-016 BBOX (1 cycle): register xmin/xmax/ymin/ymax as unsigned min/max of the three vertex coordinates; load px=xmin, py=ymin; go to SCAN.
REQ-017 SCAN (1 cycle per point): if entrada=1, load pix_x=px, pix_y=py, set pix_valid, go to EMIT; else advance.
REQ-018 EMIT: hold pix_valid, pix_x, pix_y, px, py stable while pix_ready=0; on pix_ready=1, clear pix_valid, increment contagem, advance.
REQ-019 Advance: if px<xmax then px+1; else px=xmin, py+1; return to SCAN.
REQ-020 If px=xmax and py=ymax when advancing, go to DONE instead; no increment past xmax/ymax, so a bbox edge at 2^W-1 never wraps.
REQ-021 DONE (1 cycle): fim=1, go to IDLE; contagem and last px, py hold until next accepted inicio.
REQ-022 Scan order row-major, x fastest, from (xmin,ymin) to (xmax,ymax) inclusive; each bbox point presented exactly once.
REQ-023 Timing: inicio at edge k -> BBOX cycle k+1 -> first point on px/py in cycle k+2; outside point costs 1 cycle, inside point 2 cycles with pix_ready high.
REQ-024 Degenerate bbox (coincident or collinear vertices, xmin=xmax and/or ymin=ymax) SHALL scan the single row/column/point and terminate normally.
REQ-025 inicio while ocupado=1 ignored; pix_ready outside EMIT ignored.
REQ-026 contagem saturates at 2^CW-1.
REQ-027 pix_valid never drops without pix_ready (no retraction); entrada ignored in EMIT.

Reset
REQ-028 rst=1 at any time, including mid-scan or mid-EMIT, forces IDLE immediately; px, py, pix_x, pix_y, contagem, vertex and bbox registers = 0; pix_valid, ocupado, fim = 0.
REQ-029 After rst release, block waits for a new inicio; no partial scan resumes.

Verification
REQ-030 Bench SHALL pair block with tester (or golden model) and compare emitted pixel list against model, cover:
REQ-031 Vertices (15,15),(35,10),(15,30), pix_ready=1 -> bbox x15..35, y10..30; 441 points in row-major order; contagem = model inside count; fim once; cycles = 2+441+contagem.
REQ-032 All vertices (5,5), model entrada=1 -> single pixel (5,5), contagem=1, fim in cycle k+4.
REQ-033 Same triangle, pix_ready held low 10 cycles on first inside pixel -> pix_valid, pix_x, pix_y, px, py stable 10 cycles; final contagem unchanged vs REQ-031.
REQ-034 Vertices (4090,4095),(4095,4090),(4095,4095) -> scan ends at (4095,4095) with no wrap to 0; fim asserted.
REQ-035 rst pulse mid-scan of REQ-031 triangle -> all outputs 0 asynchronously; new inicio rescans from (15,10); inicio pulses during ocupado=1 have no effect.
